// File: rtl/zmod_dac_cfg_sequencer_if.sv
// Runtime register-write port of the AD9717 configuration sequencer.
//   i_wr_valid  : write request from system control logic
//   i5_wr_addr  : DAC register address
//   i8_wr_data  : DAC register data
//   o_wr_ready  : sequencer can accept a write (valid & ready = accepted)
interface zmod_dac_cfg_sequencer_if;
    logic       i_wr_valid;
    logic [4:0] i5_wr_addr;
    logic [7:0] i8_wr_data;
    logic       o_wr_ready;

    modport master (
        output i_wr_valid,
        output i5_wr_addr,
        output i8_wr_data,
        input  o_wr_ready
    );

    modport slave (
        input  i_wr_valid,
        input  i5_wr_addr,
        input  i8_wr_data,
        output o_wr_ready
    );
endinterface

// File: rtl/zmod_dac_cfg_sequencer.sv
// Configuration controller for the AD9717 ZMOD DAC.
// On enable: pulse the DAC hardware reset, wait, write the init table over
// 3-wire SPI, then raise o_run and serve runtime register writes.
//   clk, rst   : system clock, synchronous active-high reset
//   i_en       : level enable; low returns to IDLE (after any frame + gap)
//   wr         : runtime write port (valid/ready, 5-bit addr, 8-bit data)
//   o_run      : init complete, DAC datapath may run
//   o_busy     : SPI frame in progress (cs low)
//   o_dac_rst  : DAC hardware reset, active high
//   or_sck     : SPI clock, idle high
//   or_cs      : SPI chip select, active low
//   o_sdo      : SPI data, MSB first, changes on sck falling edges
module zmod_dac_cfg_sequencer #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned RST_CYCLES  = 16,
    parameter int unsigned WAIT_CYCLES = 256,
    parameter int unsigned INIT_LEN    = 4,
    // entry i = INIT_TABLE[13*i +: 13] = {addr[12:8], data[7:0]}
    parameter logic [INIT_LEN*13-1:0] INIT_TABLE =
        {13'h1400, 13'h0200, 13'h0100, 13'h0000}
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_en,
    zmod_dac_cfg_sequencer_if.slave         wr,
    output logic                            o_run,
    output logic                            o_busy,
    output logic                            o_dac_rst,
    output logic                            or_sck,
    output logic                            or_cs,
    output logic                            o_sdo
);

    localparam int unsigned GAP_CYCLES = 2 * CLK_DIV;
    localparam int unsigned MAX_A      = (CLK_DIV > RST_CYCLES) ? CLK_DIV : RST_CYCLES;
    localparam int unsigned MAX_B      = (MAX_A > WAIT_CYCLES) ? MAX_A : WAIT_CYCLES;
    localparam int unsigned DIV_MAX    = (MAX_B > GAP_CYCLES) ? MAX_B : GAP_CYCLES;
    localparam int unsigned DIV_W      = $clog2(DIV_MAX);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] RST_LAST  = DIV_W'(RST_CYCLES - 1);
    localparam logic [DIV_W-1:0] WAIT_LAST = DIV_W'(WAIT_CYCLES - 1);
    localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       IDX_LAST  = 4'(INIT_LEN - 1);

    // LEAD: cs low, sck high before first fall; LO/HI: sck half-periods;
    // TRAIL: one extra half-period after the last high phase; GAP: cs high.
    typedef enum logic [3:0] {
        S_IDLE, S_HWRST, S_WAIT, S_LEAD, S_LO, S_HI, S_TRAIL, S_GAP, S_RUN
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div;
    logic [3:0]        bit_cnt;
    logic [3:0]        idx;
    logic [15:0]       frame;
    logic [12:0]       init_rom [16];
    logic [3:0]        next_idx_c;
    logic [15:0]       load_word_c;

    // Init table unpacked into a 16-entry ROM so the 4-bit index is always in range
    for (genvar g = 0; g < 16; g++) begin : g_rom
        if (g < INIT_LEN) begin : g_used
            assign init_rom[g] = INIT_TABLE[13*g +: 13];
        end else begin : g_unused
            assign init_rom[g] = '0;
        end
    end

    // Word for the frame about to start: runtime write in RUN, else next init entry
    always_comb begin
        next_idx_c  = idx + 4'd1;
        load_word_c = {3'b000, init_rom[(state == S_WAIT) ? 4'd0 : next_idx_c]};
        if (state == S_RUN) begin
            load_word_c = {3'b000, wr.i5_wr_addr, wr.i8_wr_data};
        end
    end

    // Sequencer FSM with registered SPI and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            div           <= '0;
            bit_cnt       <= '0;
            idx           <= '0;
            frame         <= '0;
            o_run         <= 1'b0;
            o_busy        <= 1'b0;
            wr.o_wr_ready <= 1'b0;
            o_dac_rst     <= 1'b0;
            or_sck        <= 1'b1;
            or_cs         <= 1'b1;
            o_sdo         <= 1'b0;
        end else begin
            div <= div + DIV_W'(1);
            case (state)
                S_IDLE: begin
                    div           <= '0;
                    o_run         <= 1'b0;
                    wr.o_wr_ready <= 1'b0;
                    if (i_en) begin
                        state     <= S_HWRST;
                        o_dac_rst <= 1'b1;
                    end
                end
                S_HWRST: begin
                    if (!i_en || div == RST_LAST) begin
                        state     <= i_en ? S_WAIT : S_IDLE;
                        o_dac_rst <= 1'b0;
                        div       <= '0;
                    end
                end
                S_WAIT: begin
                    if (!i_en) begin
                        state <= S_IDLE;
                    end else if (div == WAIT_LAST) begin
                        state   <= S_LEAD;
                        div     <= '0;
                        idx     <= '0;
                        bit_cnt <= 4'd15;
                        frame   <= load_word_c;
                        o_sdo   <= load_word_c[15];
                        or_cs   <= 1'b0;
                        o_busy  <= 1'b1;
                    end
                end
                S_LEAD: begin
                    if (div == DIV_LAST) begin
                        state  <= S_LO;
                        div    <= '0;
                        or_sck <= 1'b0;
                    end
                end
                S_LO: begin
                    if (div == DIV_LAST) begin
                        state  <= S_HI;
                        div    <= '0;
                        or_sck <= 1'b1;
                    end
                end
                S_HI: begin
                    if (div == DIV_LAST) begin
                        div <= '0;
                        if (bit_cnt == 4'd0) begin
                            state <= S_TRAIL;
                        end else begin
                            state   <= S_LO;
                            bit_cnt <= bit_cnt - 4'd1;
                            o_sdo   <= frame[bit_cnt - 4'd1];
                            or_sck  <= 1'b0;
                        end
                    end
                end
                S_TRAIL: begin
                    if (div == DIV_LAST) begin
                        state  <= S_GAP;
                        div    <= '0;
                        or_cs  <= 1'b1;
                        o_busy <= 1'b0;
                        o_sdo  <= 1'b0;
                    end
                end
                S_GAP: begin
                    // A dropped enable is honoured only once the frame and gap are done
                    if (div == GAP_LAST) begin
                        div <= '0;
                        if (!i_en) begin
                            state <= S_IDLE;
                            o_run <= 1'b0;
                        end else if (o_run || idx == IDX_LAST) begin
                            state         <= S_RUN;
                            o_run         <= 1'b1;
                            wr.o_wr_ready <= 1'b1;
                        end else begin
                            state   <= S_LEAD;
                            idx     <= next_idx_c;
                            bit_cnt <= 4'd15;
                            frame   <= load_word_c;
                            o_sdo   <= load_word_c[15];
                            or_cs   <= 1'b0;
                            o_busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (!i_en) begin
                        state         <= S_IDLE;
                        o_run         <= 1'b0;
                        wr.o_wr_ready <= 1'b0;
                    end else if (wr.i_wr_valid && wr.o_wr_ready) begin
                        state         <= S_LEAD;
                        div           <= '0;
                        wr.o_wr_ready <= 1'b0;
                        bit_cnt       <= 4'd15;
                        frame         <= load_word_c;
                        o_sdo         <= load_word_c[15];
                        or_cs         <= 1'b0;
                        o_busy        <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zmod_dac_cfg_sequencer.sv
// Directed self-checking bench for zmod_dac_cfg_sequencer with an SPI frame monitor.
module tb_zmod_dac_cfg_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_en = 1'b0;
    logic o_run, o_busy, o_dac_rst, or_sck, or_cs, o_sdo;

    zmod_dac_cfg_sequencer_if wr_if ();

    zmod_dac_cfg_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .i_en      (i_en),
        .wr        (wr_if),
        .o_run     (o_run),
        .o_busy    (o_busy),
        .o_dac_rst (o_dac_rst),
        .or_sck    (or_sck),
        .or_cs     (or_cs),
        .o_sdo     (o_sdo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // SPI monitor state
    logic [15:0] frames [$];
    int          lens   [$];
    int          rises  [$];
    int          gaps   [$];
    logic [15:0] cur_word = '0;
    int          cur_len = 0, cur_rises = 0, gap_len = 0, total_edges = 0;
    logic        prev_cs = 1'b1, prev_sck = 1'b1;

    // Handshake monitor state
    int          hs_count = 0;
    longint      hs_times [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Decode SPI: sample sdo on sck rise while cs low, log frame, length, rises, gap
    initial forever begin
        @(negedge clk);
        if (prev_sck != or_sck) total_edges++;
        if (!or_cs) begin
            if (prev_cs) begin
                gaps.push_back(gap_len);
                cur_len = 0; cur_rises = 0; cur_word = '0;
            end
            cur_len++;
            if (!prev_sck && or_sck) begin
                cur_word = {cur_word[14:0], o_sdo};
                cur_rises++;
            end
        end else begin
            if (!prev_cs) begin
                frames.push_back(cur_word);
                lens.push_back(cur_len);
                rises.push_back(cur_rises);
                gap_len = 0;
            end
            gap_len++;
        end
        prev_cs  = or_cs;
        prev_sck = or_sck;
    end

    initial forever begin
        @(posedge clk);
        if (wr_if.i_wr_valid && wr_if.o_wr_ready) begin
            hs_count++;
            hs_times.push_back($time);
        end
    end

    initial begin
        int n, m, fb, gb, hb, e0;
        logic [15:0] exp_init [4];
        exp_init[0] = 16'h0000; exp_init[1] = 16'h0100;
        exp_init[2] = 16'h0200; exp_init[3] = 16'h1400;
        wr_if.i_wr_valid = 1'b0;
        wr_if.i5_wr_addr = '0;
        wr_if.i8_wr_data = '0;

        // 1: reset values, then hardware reset pulse and wait time
        i_en = 1'b1;
        repeat (3) step();
        check("rst_run",   o_run, 0);
        check("rst_busy",  o_busy, 0);
        check("rst_ready", wr_if.o_wr_ready, 0);
        check("rst_dacrst", o_dac_rst, 0);
        check("rst_sck",   or_sck, 1);
        check("rst_cs",    or_cs, 1);
        check("rst_sdo",   o_sdo, 0);
        rst = 1'b0;
        for (n = 0; n < 10 && !o_dac_rst; n++) step();
        if (n >= 10) check("tmo_dacrst_rise", 0, 1);
        n = 0;
        while (o_dac_rst && n < 100) begin n++; step(); end
        check("dacrst_len", n, 16);
        m = 0;
        while (or_cs && m < 1000) begin m++; step(); end
        check("wait_len", m, 256);

        // 2: init table frames
        for (n = 0; n < 2000 && !o_run; n++) step();
        if (n >= 2000) check("tmo_run", 0, 1);
        check("init_nframes", frames.size(), 4);
        check("run_cs_high", or_cs, 1);
        for (int i = 0; i < 4 && i < frames.size(); i++) begin
            check($sformatf("init_frame%0d", i), frames[i], exp_init[i]);
            check($sformatf("init_len%0d", i), lens[i], 136);
            check($sformatf("init_rises%0d", i), rises[i], 16);
            if (i > 0) check($sformatf("init_gap%0d", i), gaps[i] >= 8, 1);
        end

        // 3: runtime write handshake
        step();
        check("run_ready", wr_if.o_wr_ready, 1);
        fb = frames.size();
        wr_if.i_wr_valid = 1'b1; wr_if.i5_wr_addr = 5'h03; wr_if.i8_wr_data = 8'hA5;
        step();
        wr_if.i_wr_valid = 1'b0;
        check("hs_ready_drop", wr_if.o_wr_ready, 0);
        check("hs_cs_low", or_cs, 0);
        check("hs_busy", o_busy, 1);
        check("hs_count1", hs_count, 1);
        for (n = 0; n < 300 && frames.size() == fb; n++) step();
        if (frames.size() == fb) check("tmo_wr_frame", 0, 1);
        else begin
            check("wr_frame", frames[fb], 16'h03A5);
            check("wr_len", lens[fb], 136);
        end
        check("wr_run_held", o_run, 1);
        n = 0;
        while (!wr_if.o_wr_ready && n < 100) begin n++; step(); end
        check("ready_after_gap", (n >= 8) && (n < 100), 1);

        // 4: request held through init
        i_en = 1'b0;
        step(); step();
        check("idle_run", o_run, 0);
        check("idle_ready", wr_if.o_wr_ready, 0);
        fb = frames.size();
        hb = hs_count;
        wr_if.i_wr_valid = 1'b1; wr_if.i5_wr_addr = 5'h0A; wr_if.i8_wr_data = 8'h5C;
        i_en = 1'b1;
        for (n = 0; n < 2000 && !o_run; n++) begin
            if (wr_if.o_wr_ready) check("early_ready", wr_if.o_wr_ready, 0);
            step();
        end
        if (n >= 2000) check("tmo_run2", 0, 1);
        check("no_hs_in_init", hs_count, hb);
        check("init2_nframes", frames.size() - fb, 4);
        step();
        check("held_hs", hs_count, hb + 1);
        wr_if.i5_wr_addr = 5'h1F; wr_if.i8_wr_data = 8'h81;
        for (n = 0; n < 400 && hs_count < hb + 2; n++) step();
        wr_if.i_wr_valid = 1'b0;
        if (hs_count < hb + 2) check("tmo_hs2", 0, 1);
        else check("hs_spacing", ((hs_times[hb+1] - hs_times[hb]) / 10) >= 144, 1);
        for (n = 0; n < 400 && frames.size() < fb + 6; n++) step();
        if (frames.size() < fb + 6) check("tmo_wr_frames", 0, 1);
        else begin
            check("held_frame", frames[fb+4], 16'h0A5C);
            check("second_frame", frames[fb+5], 16'h1F81);
        end
        repeat (20) step();
        check("hs_total", hs_count, hb + 2);

        // 5: enable dropped mid-frame 2 of init
        i_en = 1'b0;
        step(); step();
        i_en = 1'b1;
        fb = frames.size();
        gb = gaps.size();
        for (n = 0; n < 1500 && gaps.size() < gb + 3; n++) step();
        for (m = 0; m < 200 && cur_rises < 8; m++) step();
        if (n >= 1500 || m >= 200) check("tmo_frame2", 0, 1);
        i_en = 1'b0;
        for (n = 0; n < 300 && frames.size() < fb + 3; n++) step();
        if (frames.size() < fb + 3) check("tmo_frame2_end", 0, 1);
        else begin
            check("drop_frame", frames[fb+2], 16'h0200);
            check("drop_rises", rises[fb+2], 16);
        end
        repeat (12) step();
        check("drop_run", o_run, 0);
        check("drop_busy", o_busy, 0);
        check("drop_no_next", gaps.size() - gb, 3);
        check("drop_dacrst", o_dac_rst, 0);
        i_en = 1'b1;
        step();
        check("reenable_hwrst", o_dac_rst, 1);

        // 6: reset at bit 10 of a frame
        gb = gaps.size();
        for (n = 0; n < 600 && gaps.size() == gb; n++) step();
        for (m = 0; m < 200 && cur_rises < 10; m++) step();
        if (n >= 600 || m >= 200) check("tmo_frame_rst", 0, 1);
        rst = 1'b1; i_en = 1'b0;
        step();
        check("mrst_cs",    or_cs, 1);
        check("mrst_sck",   or_sck, 1);
        check("mrst_busy",  o_busy, 0);
        check("mrst_run",   o_run, 0);
        check("mrst_ready", wr_if.o_wr_ready, 0);
        check("mrst_dacrst", o_dac_rst, 0);
        check("mrst_sdo",   o_sdo, 0);
        rst = 1'b0;
        e0 = total_edges;
        repeat (300) step();
        check("mrst_no_sck", total_edges, e0);
        check("mrst_cs_idle", or_cs, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
